// File: rtl/lifo_pkg.sv
// ---------------------------------------------------------------------------
// lifo_pkg
//  Shared definitions for the lifo drain path.
//   PTR_W        width of the output-buffer head/tail pointers (2 entries)
//   CNT_W        width of the output-buffer occupancy count (range 0..2)
//   WORD_W       word width carried by lifo_word_t
//   lifo_word_t  buffer entry {data, last}; used only when the top is built
//                with LIFO_POP_LAST_EN defined
// ---------------------------------------------------------------------------
package lifo_pkg;

    localparam int PTR_W  = 1;
    localparam int CNT_W  = 2;
    localparam int WORD_W = 8;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
    } lifo_word_t;

endpackage

// File: rtl/lifo_obuf2.sv
// ---------------------------------------------------------------------------
// lifo_obuf2
//  Two-entry register FIFO. Used as the output buffer of lifo_pop_stream.
//  Push and pop may happen on the same edge (count unchanged).
//  Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   push       in   write push_data at the tail on this edge
//   push_data  in   W-bit entry to write
//   pop        in   drop the head entry on this edge
//   head_data  out  W-bit head entry (oldest word)
//   count      out  occupancy, 0..2
// ---------------------------------------------------------------------------
module lifo_obuf2
    import lifo_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [2];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: the two entries are reset as well, because the head entry is
            // the visible output word and must read 0 straight out of reset.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];

    // The credit logic upstream must never push into a full buffer or pop an
    // empty one.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == 2'd2));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop && count == 2'd0));

endmodule

// File: rtl/lifo_pop_stream.sv
// ---------------------------------------------------------------------------
// lifo_pop_stream
//  Drain stage for a lifo with one-cycle read latency. Issues pops (rd_en)
//  only when the 2-entry output buffer is guaranteed to have room for the
//  word once it arrives, and presents the words as a valid/ready stream in
//  pop order (LIFO order preserved). Sustains one word per cycle when the
//  consumer is always ready.
//  Optional build macro: LIFO_POP_LAST_EN adds out_last, which marks the word
//  whose pop drained the lifo.
//  Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   lifo_empty   in   lifo is empty
//   data_rd      in   lifo read data, valid the cycle after rd_en
//   rd_en        out  pop request to the lifo
//   enable       in   0 = issue no new pops (buffered/in-flight words drain)
//   out_valid    out  out_data holds a word
//   out_data     out  head word of the output buffer
//   out_ready    in   consumer accepts the word this cycle
//   pop_pending  out  a pop was issued last cycle, its data not yet captured
//   out_last     out  (LIFO_POP_LAST_EN only) this word emptied the lifo
// ---------------------------------------------------------------------------
module lifo_pop_stream
    import lifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lifo_empty,
    input  logic [DATA_WIDTH-1:0] data_rd,
    output logic                  rd_en,
    input  logic                  enable,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  pop_pending
`ifdef LIFO_POP_LAST_EN
    ,
    output logic                  out_last
`endif
);

    if (BUF_DEPTH != 2) begin : g_bad_depth
        $error("lifo_pop_stream: BUF_DEPTH must be 2");
    end

`ifdef LIFO_POP_LAST_EN
    if (DATA_WIDTH != WORD_W) begin : g_bad_width
        $error("lifo_pop_stream: DATA_WIDTH must equal lifo_pkg::WORD_W with LIFO_POP_LAST_EN");
    end
    localparam int ENTRY_W = $bits(lifo_word_t);
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic [CNT_W-1:0]   count;
    logic               inflight;
    logic               xfer;
    logic [CNT_W:0]     used;

    assign out_valid   = (count != '0);
    assign xfer        = out_valid & out_ready;
    assign pop_pending = inflight;

    // Credit check: words already buffered plus the one in flight, minus the
    // one leaving this edge, must leave a free slot for a new pop. xfer implies
    // count >= 1, so the subtraction never underflows. rd_en is forced low
    // while rst is asserted so no pop escapes during reset.
    // NOTE: every combinational output gets a value on every path (here by
    // straight assignments), so no latch can be inferred.
    always_comb begin
        used  = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, xfer};
        rd_en = !rst && enable && !lifo_empty && (used < (CNT_W+1)'(2));
    end

    // The lifo answers a pop one cycle later; remember that a word is coming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
        end
    end

`ifdef LIFO_POP_LAST_EN
    lifo_word_t push_w;
    lifo_word_t head_w;

    // lifo_empty on the capture edge reflects the lifo after this word's pop,
    // so it flags the word that drained it.
    assign push_w    = '{data: data_rd, last: lifo_empty};
    assign push_data = push_w;
    assign head_w    = head_data;
    assign out_data  = head_w.data;
    assign out_last  = out_valid & head_w.last;
`else
    assign push_data = data_rd;
    assign out_data  = head_data;
`endif

    lifo_obuf2 #(
        .W (ENTRY_W)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (push_data),
        .pop       (xfer),
        .head_data (head_data),
        .count     (count)
    );

endmodule

// File: tb/tb_lifo_pop_stream.sv
// ---------------------------------------------------------------------------
// tb_lifo_pop_stream
//  Bench for lifo_pop_stream with a 12-deep, 8-bit behavioural lifo in front
//  of it. Stimulus pushes the hand-ordered expected words into a queue; a
//  monitor pops and compares on every accepted output word.
//  Build with LIFO_POP_LAST_EN defined to also check out_last.
// ---------------------------------------------------------------------------
module tb_lifo_pop_stream;

    localparam int DW    = 8;
    localparam int DEPTH = 12;

    logic          clk;
    logic          rst;
    logic          lifo_empty;
    logic [DW-1:0] data_rd;
    logic          rd_en;
    logic          enable;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          pop_pending;
`ifdef LIFO_POP_LAST_EN
    logic          out_last;
`endif

    lifo_pop_stream #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lifo_empty  (lifo_empty),
        .data_rd     (data_rd),
        .rd_en       (rd_en),
        .enable      (enable),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .pop_pending (pop_pending)
`ifdef LIFO_POP_LAST_EN
        ,
        .out_last    (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural lifo: registered read, not tied to the DUT reset so a DUT
    // reset leaves the remaining lifo contents in place.
    logic [DW-1:0] stack [DEPTH];
    int            sp = 0;
    logic          lf_wr;
    logic [DW-1:0] lf_wd;

    always @(posedge clk) begin
        if (rd_en && sp > 0) begin
            data_rd <= stack[sp-1];
            sp      <= sp - 1;
        end else if (lf_wr && sp < DEPTH) begin
            stack[sp] <= lf_wd;
            sp        <= sp + 1;
        end
    end
    assign lifo_empty = (sp == 0);

    // Scoreboard and counters
    logic [DW-1:0] exp_q [$];
    logic          exp_last_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int xfer_cnt = 0;
    int first_xfer_cyc = 0;
    int last_xfer_cyc  = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
`ifdef LIFO_POP_LAST_EN
    logic          prev_last = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic expect_word(input logic [DW-1:0] d, input logic l);
        exp_q.push_back(d);
        exp_last_q.push_back(l);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lifo_write(input logic [DW-1:0] v);
        lf_wr = 1'b1;
        lf_wd = v;
        tick();
        lf_wr = 1'b0;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic [DW-1:0] d;
        logic          l;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, prev_data);
`ifdef LIFO_POP_LAST_EN
                    check("hold_last", out_last, prev_last);
`endif
                end
                if (rd_en) begin
                    rd_cnt++;
                    check("pop_nonempty", lifo_empty, 0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_word: got 0x%0h, want no word", out_data);
                    end else begin
                        d = exp_q.pop_front();
                        l = exp_last_q.pop_front();
                        check("stream_data", out_data, d);
`ifdef LIFO_POP_LAST_EN
                        check("stream_last", out_last, l);
`endif
                    end
                    if (xfer_cnt == 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                    xfer_cnt++;
                end
                hold_prev = out_valid && !out_ready;
                prev_data = out_data;
`ifdef LIFO_POP_LAST_EN
                prev_last = out_last;
`endif
            end
        end
    end

    initial begin
        int bad;
        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        lf_wr     = 1'b0;
        lf_wd     = '0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_pop_pending", pop_pending, 0);
        rst = 1'b0;
        tick();

        // 1: three words drain in LIFO order on consecutive cycles
        lifo_write(8'h05);
        lifo_write(8'h09);
        lifo_write(8'hA3);
        expect_word(8'hA3, 1'b0);
        expect_word(8'h09, 1'b0);
        expect_word(8'h05, 1'b1);
        rd_cnt = 0;
        xfer_cnt = 0;
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (8) tick();
        check("t1_rd_cnt", rd_cnt, 3);
        check("t1_lifo_empty", lifo_empty, 1);
        check("t1_xfer_cnt", xfer_cnt, 3);
        check("t1_no_gap", last_xfer_cyc - first_xfer_cyc, 2);
        check("t1_sb_empty", exp_q.size(), 0);

        // 2: full lifo under backpressure, then stream with no gaps
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) lifo_write(8'h10 + 8'(i));
        out_ready = 1'b0;
        rd_cnt = 0;
        xfer_cnt = 0;
        enable = 1'b1;
        repeat (8) tick();
        check("t2_hold_pops", rd_cnt, 2);
        check("t2_hold_rd_en", rd_en, 0);
        check("t2_hold_valid", out_valid, 1);
        check("t2_hold_data", out_data, 8'h1B);
        for (int i = DEPTH - 1; i >= 0; i--) expect_word(8'h10 + 8'(i), i == 0);
        out_ready = 1'b1;
        repeat (16) tick();
        check("t2_xfer_cnt", xfer_cnt, 12);
        check("t2_no_gap", last_xfer_cyc - first_xfer_cyc, 11);
        check("t2_rd_cnt", rd_cnt, 12);
        check("t2_sb_empty", exp_q.size(), 0);

        // 3: random backpressure
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) lifo_write(8'h40 + 8'(3 * i));
        for (int i = DEPTH - 1; i >= 0; i--) expect_word(8'h40 + 8'(3 * i), i == 0);
        xfer_cnt = 0;
        enable = 1'b1;
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        repeat (4) tick();
        check("t3_sb_empty", exp_q.size(), 0);
        check("t3_xfer_cnt", xfer_cnt, 12);
        check("t3_idle_valid", out_valid, 0);

        // 4: empty lifo stays idle; one write gives one pop and one word
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rd_en || out_valid) bad++;
        end
        check("t4_idle", bad, 0);
        expect_word(8'h7E, 1'b1);
        lifo_write(8'h7E);
        check("t4_rd_en_c0", rd_en, 1);
        check("t4_valid_c0", out_valid, 0);
        tick();
        check("t4_rd_en_c1", rd_en, 0);
        check("t4_pending_c1", pop_pending, 1);
        tick();
        check("t4_valid_c2", out_valid, 1);
        check("t4_data_c2", out_data, 8'h7E);
        repeat (3) tick();
        check("t4_sb_empty", exp_q.size(), 0);

        // 5: reset with one word buffered and one in flight
        enable = 1'b0;
        out_ready = 1'b0;
        lifo_write(8'h61);
        lifo_write(8'h62);
        lifo_write(8'h63);
        enable = 1'b1;
        tick();
        tick();
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_pending", pop_pending, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_rd_en", rd_en, 0);
        check("t5_rst_pending", pop_pending, 0);
        tick();
        rst = 1'b0;
        xfer_cnt = 0;
        expect_word(8'h61, 1'b1);
        out_ready = 1'b1;
        repeat (8) tick();
        check("t5_xfer_cnt", xfer_cnt, 1);
        check("t5_sb_empty", exp_q.size(), 0);
        check("t5_lifo_empty", lifo_empty, 1);

`ifdef LIFO_POP_LAST_EN
        // 6: last flag marks the word that drained the lifo
        enable = 1'b0;
        lifo_write(8'h01);
        lifo_write(8'h02);
        lifo_write(8'h03);
        expect_word(8'h03, 1'b0);
        expect_word(8'h02, 1'b0);
        expect_word(8'h01, 1'b1);
        enable = 1'b1;
        repeat (8) tick();
        check("t6_sb_empty", exp_q.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
